// File: rtl/node_settle_sequencer.sv
// Switch-level net resolution stage: merges driver words per node and
// iterates one resolve per clock until the network stops changing.
module node_settle_sequencer #(
    parameter int NNODES   = 8,
    parameter int NDRV     = 4,
    parameter int W        = 4,
    parameter int MAX_ITER = 64,
    parameter int CW       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NNODES*NDRV*W-1:0] drv_in,
    output logic [NNODES*W-1:0]      node_out,
    output logic                     busy,
    output logic                     done,
    output logic                     settled,
    output logic                     timeout,
    output logic [CW-1:0]            iter_count
);

    typedef enum logic [1:0] {
        IDLE,
        RESOLVE,
        DONE
    } state_e;

    state_e              state_q;
    logic [NNODES*W-1:0] node_q;
    logic [NNODES*W-1:0] node_d;
    logic [CW-1:0]       iter_q;
    logic [CW-1:0]       iter_d;
    logic                busy_q;
    logic                done_q;
    logic                settled_q;
    logic                timeout_q;

    logic [W-2:0]        smax;
    logic [W-2:0]        dstr;
    logic                lo_hit;
    logic                changed;

    // Strongest driver wins; a tie at the top strength resolves low.
    // With no active driver a previously driven node decays to charge.
    always_comb begin
        node_d = '0;
        smax   = '0;
        dstr   = '0;
        lo_hit = 1'b0;
        for (int n = 0; n < NNODES; n++) begin
            smax   = '0;
            lo_hit = 1'b0;
            for (int d = 0; d < NDRV; d++) begin
                dstr = drv_in[((n*NDRV)+d)*W+1 +: W-1];
                if (dstr > smax) smax = dstr;
            end
            for (int d = 0; d < NDRV; d++) begin
                dstr = drv_in[((n*NDRV)+d)*W+1 +: W-1];
                if (dstr == smax && !drv_in[((n*NDRV)+d)*W])
                    lo_hit = 1'b1;
            end
            if (smax != '0)
                node_d[n*W +: W] = {smax, ~lo_hit};
            else if (node_q[n*W+1 +: W-1] != '0)
                node_d[n*W +: W] = {(W-1)'(1), node_q[n*W]};
            else
                node_d[n*W +: W] = '0;
        end
    end

    assign changed = (node_d != node_q);
    assign iter_d  = iter_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            node_q    <= '0;
            iter_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            settled_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RESOLVE;
                        iter_q    <= '0;
                        settled_q <= 1'b0;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                RESOLVE: begin
                    node_q <= node_d;
                    iter_q <= iter_d;
                    if (!changed) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        settled_q <= 1'b1;
                    end else if (iter_d == CW'(MAX_ITER)) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign node_out   = node_q;
    assign iter_count = iter_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign settled    = settled_q;
    assign timeout    = timeout_q;

endmodule

// File: doc/node_settle_sequencer.md
Name: node_settle_sequencer

Overview:
- Clocked net-resolution stage that sits directly downstream of the switch-level transistor, pullup and pad models.
- It collects every driver contribution per node, resolves each node to one strength/level word, and registers the result.
- The registered node values feed back to the transistor gates and channel inputs.
- It iterates one resolution per clock until the network is stable or an iteration limit is hit, then reports completion to the simulation top.

Parameters:
- NNODES, 8, number of resolved nodes
- NDRV, 4, driver contributions per node
- W, 4, word width: bit 0 = level (1 = hi), bits [3:1] = strength
- MAX_ITER, 64, iteration limit before timeout
- CW, 8, width of iter_count; must satisfy 2^CW > MAX_ITER

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin settling
- drv_in  in  NNODES*NDRV*W  driver words; node n, driver d at index ((n*NDRV)+d)*W
- node_out  out  NNODES*W  registered resolved node words; node n at index n*W
- busy  out  1  high while settling
- done  out  1  one-cycle pulse when settling ends
- settled  out  1  high if the last settle converged
- timeout  out  1  high if the last settle hit MAX_ITER
- iter_count  out  CW  resolve cycles used by the current or last settle

Behaviour:
- Reset is asynchronous and active-low, on one clock.
- Reset values: node_out all zero (strength 0 = off, level lo), busy=0, done=0, settled=0, timeout=0, iter_count=0, state=IDLE.
- Strength encoding: 0 = off; 1 = charge (stored only, never produced by drivers); higher values are compared numerically, and the greater value wins.
- Per-node resolution (combinational, from drv_in and current node_out):
  - smax = max strength over the NDRV drivers.
  - If smax > 0: strength = smax. Level = lo if any driver at strength smax is lo, else hi. Equal-strength conflict resolves low.
  - If smax == 0 and current strength != 0: strength = 1, level = current level (charge retention).
  - If smax == 0 and current strength == 0: node stays 0.
- States: IDLE, RESOLVE, DONE.
- IDLE:
  - node_out holds.
  - start=1 -> RESOLVE; on that edge iter_count<=0, settled<=0, timeout<=0, busy<=1.
- RESOLVE, each clock edge:
  - node_out <= resolved values for all nodes.
  - iter_count <= iter_count+1.
  - changed = any bit of resolved != node_out, including strength bits.
  - If !changed -> DONE and settled<=1.
  - Else if iter_count+1 == MAX_ITER -> DONE and timeout<=1.
  - Else remain in RESOLVE.
- DONE: done=1 for exactly one cycle, busy<=0, then -> IDLE. settled and timeout hold until the next accepted start.
- Minimum latency:
  - start sampled at edge k.
  - First resolve registers at edge k+1.
  - If that resolve is unchanged, done is high during the cycle after edge k+1 (k+1..k+2).
- Assertion timing: busy is high from the edge after start through the DONE cycle's end edge; done and busy are both 1 in the DONE cycle.
- start while busy (RESOLVE or DONE) is ignored. start in the IDLE cycle immediately after DONE is accepted.
- Unchanged and limit-reached on the same edge: settled wins and timeout stays 0.
- iter_count never exceeds MAX_ITER.
- Reset asserted mid-settle: immediate return to reset values; any partial node state is discarded.

Test Plan:
- Reset, then start with all drv_in=0 -> node_out stays 0, iter_count=1, done pulse 2 cycles after the start edge, settled=1.
- Node0: driver0 = strength 2/hi (pullup), driver1 = strength 4/lo, start -> node0 = 4/lo (0x8), settled=1, iter_count=1.
- Node0: two drivers both at strength 4, one hi and one lo -> node0 level lo (0x8).
- Node0 settles to 4/hi (0x9); all drivers then set to 0 and start issued -> node0 = 1/hi (0x3); a second start -> stays 0x3, iter_count=1.
- External bench loop makes node0 drive node1 inverted and node1 drive node0 directly (ring oscillator), MAX_ITER=8 -> iter_count=8, timeout=1, settled=0, one done pulse.
- start held high during RESOLVE is ignored (single done pulse); rst_n low mid-RESOLVE -> outputs zero asynchronously with no done pulse; next start works normally.
